// File: rtl/rom_seq_pkg.sv
// Shared types and default sizing for the ROM stream sequencer and its output FIFO.
package rom_seq_pkg;

    localparam int ROM_AW     = 8;
    localparam int ROM_DW     = 4;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic              last;
        logic [ROM_DW-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/rom_seq_fifo.sv
// Small synchronous FIFO with a first-word-fall-through head; holds {last, data} words.
module rom_seq_fifo
    import rom_seq_pkg::*;
#(
    parameter  int DEPTH = FIFO_DEPTH,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic        CLKIN,
    input  logic        RESETN,
    input  logic        push,
    input  fifo_entry_t push_entry,
    input  logic        pop,
    output fifo_entry_t head,
    output logic        empty,
    output logic [CW-1:0] count
);

    fifo_entry_t   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Storage carries no reset: only entries below count are ever observed.
    always_ff @(posedge CLKIN) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= bump(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

    a_no_overflow: assert property (@(posedge CLKIN) disable iff (!RESETN)
        !(push && !pop && count == CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge CLKIN) disable iff (!RESETN)
        !(pop && empty));

endmodule

// File: rtl/rom_stream_sequencer.sv
// Walks an address window of a registered-read ROM and streams the words out
// over valid/ready, absorbing the one-cycle read latency in a small FIFO.
module rom_stream_sequencer
    import rom_seq_pkg::*;
#(
    parameter int AW    = ROM_AW,
    parameter int DW    = ROM_DW,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic          CLKIN,
    input  logic          RESETN,
    input  logic          START,
    input  logic [AW-1:0] BASE,
    input  logic [AW-1:0] LEN,
    output logic          BUSY,
    output logic [AW-1:0] ADDR,
    output logic          RE,
    input  logic [DW-1:0] RDATA,
    output logic [DW-1:0] DOUT,
    output logic          DVALID,
    input  logic          DREADY,
    output logic          DLAST,
    output logic          DONE,
    output state_e        state_dbg
);

    localparam int CW = $clog2(DEPTH + 1);

    state_e        state;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_hold;
    logic [AW-1:0] remaining;
    logic          inflight;
    logic          tag_q;
    logic          busy_q;
    logic          done_q;

    fifo_entry_t   push_entry;
    fifo_entry_t   head;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   occupancy;
    logic          pop;
    logic          credit;
    logic          issue;

    // Stream handshake: a word moves when DVALID && DREADY on a rising edge;
    // DVALID never waits for DREADY, and DOUT/DLAST hold while DVALID && !DREADY.
    always_comb begin
        pop       = !fifo_empty && DREADY;
        occupancy = {1'b0, fifo_count} + (CW+1)'(inflight) - (CW+1)'(pop);
        credit    = occupancy < (CW+1)'(DEPTH);
        issue     = (state == ISSUE) && credit;
    end

    assign push_entry.last = tag_q;
    assign push_entry.data = RDATA;

    rom_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
        .CLKIN      (CLKIN),
        .RESETN     (RESETN),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            addr      <= '0;
            addr_hold <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
            tag_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            inflight <= issue;
            tag_q    <= issue && (remaining == '0);
            done_q   <= 1'b0;
            if (issue) begin
                addr_hold <= addr;
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
            case (state)
                IDLE: begin
                    if (START) begin
                        addr      <= BASE;
                        remaining <= LEN;
                        busy_q    <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue && remaining == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The tagged word is the last one issued, so popping it
                    // leaves both the FIFO and the read pipeline empty.
                    if (pop && head.last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign RE        = issue;
    assign ADDR      = issue ? addr : addr_hold;
    assign DVALID    = !fifo_empty;
    assign DOUT      = fifo_empty ? '0 : head.data;
    assign DLAST     = !fifo_empty && head.last;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_rom_stream_sequencer.sv
// Randomized bench for rom_stream_sequencer: ROM model, window-level reference queues, scoreboard.
module tb_rom_stream_sequencer;
    import rom_seq_pkg::*;

    localparam int DEPTH = 2;

    logic       CLKIN = 1'b0;
    logic       RESETN;
    logic       START = 1'b0;
    logic [7:0] BASE  = '0;
    logic [7:0] LEN   = '0;
    logic [3:0] RDATA = '0;
    logic       DREADY = 1'b0;
    logic       BUSY, RE, DVALID, DLAST, DONE;
    logic [7:0] ADDR;
    logic [3:0] DOUT;
    state_e     state_dbg;

    rom_stream_sequencer #(.AW(8), .DW(4), .DEPTH(DEPTH)) dut (
        .CLKIN     (CLKIN),
        .RESETN    (RESETN),
        .START     (START),
        .BASE      (BASE),
        .LEN       (LEN),
        .BUSY      (BUSY),
        .ADDR      (ADDR),
        .RE        (RE),
        .RDATA     (RDATA),
        .DOUT      (DOUT),
        .DVALID    (DVALID),
        .DREADY    (DREADY),
        .DLAST     (DLAST),
        .DONE      (DONE),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset / ROM ----------------
    always #5 CLKIN = ~CLKIN;

    int cyc = 0;
    always @(posedge CLKIN) cyc++;

    logic [3:0] rom [0:255];
    always @(posedge CLKIN) begin
        if (RE) RDATA <= rom[ADDR];
    end

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] exp_q[$];
    logic [7:0] addr_q[$];
    int   start_cyc     = 0;
    int   issued        = 0;
    int   popped        = 0;
    bit   pending_start = 0;
    bit   m_active      = 0;
    bit   done_pending  = 0;
    bit   first_pending = 0;
    bit   prev_stall    = 0;
    logic [3:0] prev_dout = '0;
    logic       prev_last = 1'b0;
    int   stall_last_cnt = 0;

    int ready_mode = 0;
    int pat_idx    = 0;
    int pat [5]    = '{1, 0, 0, 1, 0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- DREADY driver ----------------
    always @(posedge CLKIN) begin
        #1;
        case (ready_mode)
            0: DREADY = 1'b1;
            1: begin
                DREADY = pat[pat_idx % 5][0];
                pat_idx++;
            end
            2: DREADY = 1'($urandom_range(0, 1));
            3: DREADY = (cyc >= start_cyc + 8);
            default: DREADY = 1'b0;
        endcase
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge CLKIN) begin
        if (RESETN) begin
            logic [4:0] e;
            if (pending_start && cyc == start_cyc + 1) begin
                m_active      = 1;
                pending_start = 0;
            end
            check("busy", BUSY, m_active);
            check("done", DONE, done_pending);
            done_pending = 0;
            if (prev_stall) begin
                check("stall_valid", DVALID, 1);
                check("stall_data", DOUT, prev_dout);
                check("stall_last", DLAST, prev_last);
            end
            if (DVALID && first_pending) begin
                check("first_latency", cyc - start_cyc, 3);
                first_pending = 0;
            end
            if (RE) begin
                check("credit", ((issued - popped - int'(DVALID && DREADY)) < DEPTH), 1);
                check("re_expected", addr_q.size() > 0, 1);
                if (addr_q.size() > 0) check("addr", ADDR, addr_q.pop_front());
                issued++;
            end
            if (DVALID && DREADY) begin
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("data", DOUT, e[3:0]);
                    check("last", DLAST, e[4]);
                    if (e[4]) begin
                        done_pending = 1;
                        m_active     = 0;
                    end
                end
                popped++;
            end
            if (DVALID && !DREADY && DLAST) stall_last_cnt++;
            prev_stall = DVALID && !DREADY;
            prev_dout  = DOUT;
            prev_last  = DLAST;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_window(input logic [7:0] base, input logic [7:0] len);
        @(posedge CLKIN); #1;
        BASE  = base;
        LEN   = len;
        START = 1'b1;
        start_cyc     = cyc;
        issued        = 0;
        popped        = 0;
        first_pending = 1;
        pending_start = 1;
        for (int i = 0; i <= int'(len); i++) begin
            logic [7:0] a;
            a = base + 8'(i);
            addr_q.push_back(a);
            exp_q.push_back({(i == int'(len)), rom[a]});
        end
        @(posedge CLKIN); #1;
        START = 1'b0;
        BASE  = 8'($urandom);
        LEN   = 8'($urandom);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_active || pending_start || exp_q.size() != 0) && n < budget) begin
            @(posedge CLKIN); #1;
            n++;
        end
        check("window_timeout", n < budget, 1);
        repeat (2) begin
            @(posedge CLKIN); #1;
        end
        check("addr_q_drained", addr_q.size(), 0);
        check("idle_state", state_dbg, IDLE);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},   ADDR,   0);
        check({tag, "_re"},     RE,     0);
        check({tag, "_busy"},   BUSY,   0);
        check({tag, "_dvalid"}, DVALID, 0);
        check({tag, "_dlast"},  DLAST,  0);
        check({tag, "_done"},   DONE,   0);
        check({tag, "_dout"},   DOUT,   0);
        check({tag, "_state"},  state_dbg, IDLE);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 4'($urandom);
        RESETN = 1'b1;
        #2 RESETN = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (3) @(posedge CLKIN);
        #1 RESETN = 1'b1;

        ready_mode = 0;
        start_window(8'h10, 8'd3);
        wait_idle(200);

        start_window(8'hFE, 8'd3);
        wait_idle(200);

        ready_mode = 1;
        pat_idx    = 0;
        start_window(8'h20, 8'd7);
        wait_idle(300);

        ready_mode     = 3;
        stall_last_cnt = 0;
        start_window(8'($urandom), 8'd0);
        wait_idle(200);
        check("len0_stall_cycles", stall_last_cnt, 5);

        ready_mode = 2;
        start_window(8'h40, 8'd15);
        repeat (3) @(posedge CLKIN);
        #1;
        BASE  = 8'h80;
        LEN   = 8'd5;
        START = 1'b1;
        @(posedge CLKIN); #1;
        START = 1'b0;
        wait_idle(400);

        start_window(8'h30, 8'd20);
        repeat (5) @(posedge CLKIN);
        #1 RESETN = 1'b0;
        #1 check_reset_outputs("mid_reset");
        exp_q.delete();
        addr_q.delete();
        m_active      = 0;
        pending_start = 0;
        done_pending  = 0;
        first_pending = 0;
        prev_stall    = 0;
        @(posedge CLKIN); #1 RESETN = 1'b1;
        repeat (4) @(posedge CLKIN);
        #1;
        start_window(8'h50, 8'd5);
        wait_idle(200);

        for (int k = 0; k < 8; k++) begin
            ready_mode = int'($urandom_range(0, 2));
            start_window(8'($urandom), 8'($urandom_range(0, 40)));
            wait_idle(500);
        end

        ready_mode = 0;
        start_window(8'($urandom), 8'hFF);
        wait_idle(700);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_stream_sequencer.md
Name: rom_stream_sequencer

Overview:
- Address-generating front end for a synchronous single-port ROM built from one iCE40 block RAM in read-only mode: 256 x 4-bit, registered read, one-cycle latency.
- On a START command the block walks a contiguous address window and drives the ROM read address.
- It captures the ROM read data and presents it as a valid/ready stream with a last-word marker.
- A small output FIFO absorbs the one-cycle read latency, so downstream backpressure never loses or duplicates a word.

Parameters:
- AW, 8, ROM address width in bits; the window wraps modulo 2^AW.
- DW, 4, ROM data width in bits.
- DEPTH, 2, output FIFO depth in words; must be at least 2.

Ports:
- CLKIN  in  1  system clock; all state updates on its rising edge.
- RESETN  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle command strobe; accepted only in IDLE.
- BASE  in  AW  first address of the window; sampled when START is accepted.
- LEN  in  AW  window length minus one (words = LEN+1); sampled when START is accepted.
- BUSY  out  1  high from the cycle after START is accepted until the last word is popped.
- ADDR  out  AW  ROM read address.
- RE  out  1  ROM read enable; RDATA is valid in the cycle after RE=1.
- RDATA  in  DW  ROM read data.
- DOUT  out  DW  stream data (FIFO head).
- DVALID  out  1  stream valid.
- DREADY  in  1  stream ready; a word transfers when DVALID and DREADY are both high.
- DLAST  out  1  high with the final word of the window.
- DONE  out  1  one-cycle pulse in the cycle after the last word transfers.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State=IDLE; FIFO is emptied; the in-flight flag is cleared.
  - ADDR=0; RE=0; BUSY=0; DVALID=0; DLAST=0; DONE=0; DOUT=0.
- States:
  - IDLE: on START=1, latch addr<=BASE and remaining<=LEN, then go to ISSUE. START in any other state is ignored.
  - ISSUE: RE=1 when a credit is available. Credit means fifo_count + inflight - pop < DEPTH, where pop = DVALID & DREADY.
    - On each issue, ADDR=addr (next address is addr+1 modulo 2^AW, so 0xFF wraps to 0x00) and remaining decrements.
    - The issue made with remaining==0 is the final one; it is tagged last and the state goes to DRAIN.
  - DRAIN: RE=0. When the FIFO is empty, no read is in flight, and the last word has transferred, go to IDLE and pulse DONE.
- Data path:
  - inflight <= RE, registered together with the tag bit.
  - The cycle after RE, {tag, RDATA} is pushed into the FIFO.
  - Push and pop in the same cycle are both allowed; occupancy is then unchanged.
- The credit rule makes FIFO overflow impossible. Overflow is an assertion failure.
- DOUT, DLAST and DVALID come from the FIFO head. They are stable while DVALID=1 and DREADY=0.
- ADDR holds its last value when RE=0.
- Throughput: with DREADY held at 1, one word per cycle.
- Latency: first DVALID appears 3 cycles after START (issue in cycle +1, RDATA in +2, FIFO head in +3).
- LEN=0 produces exactly one word, with DLAST=1.
- LEN=0xFF produces 256 words covering every address once.
- Reset asserted mid-window: everything is cleared immediately and no DONE is produced.

Decomposition:
- Shared package (rom_seq_pkg) holds:
  - the state enum {IDLE, ISSUE, DRAIN};
  - default AW/DW/DEPTH constants;
  - a typedef for the FIFO entry struct {last, data[DW-1:0]}.
- One sub-module, rom_seq_fifo: a DEPTH-entry synchronous FIFO with push/pop/count, first-word-fall-through head, and the same CLKIN/RESETN.

Test Plan:
- Reset, then BASE=0x10, LEN=3, DREADY=1 -> RE on ADDR 0x10..0x13 in 4 consecutive cycles; DOUT = ROM[0x10..0x13] on 4 consecutive cycles starting 3 cycles after START; DLAST only on the 4th word; DONE one cycle later; BUSY low afterwards.
- BASE=0xFE, LEN=3 -> ADDR sequence 0xFE, 0xFF, 0x00, 0x01; the data matches those ROM locations.
- BASE=0x20, LEN=7, DREADY toggling 1,0,0,1,0,1,... -> exactly 8 words in address order, none dropped or duplicated; RE never issued when the credit check fails; DOUT stable during stalls.
- LEN=0 with DREADY=0 for 5 cycles, then 1 -> a single word with DLAST=1 held 5 cycles; DONE the cycle after the transfer.
- START pulsed again while BUSY (BASE=0x80) -> ignored; the original window completes unchanged.
- RESETN pulled low for 1 cycle mid-window -> all outputs 0 at once, no DONE; a new START afterwards runs normally.
